// File: rtl/uart_rx.sv
// uart_rx: 16x oversampling serial receiver (8N1 by default).
// The serial line is synchronised, each bit is decided by a 3-sample
// majority vote around mid-bit, and each good byte is presented as a
// one-cycle strobe on new_rx_data with the byte on rx_data.
// Optional build macro UART_RX_PARITY_EN adds an even parity bit
// between the data bits and the stop bit, reported on parity_err.
module uart_rx #(
  parameter int BAUD_DIV = 27,
  parameter int CNT_W    = $clog2(BAUD_DIV)
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       ser_in,
  output logic [7:0] rx_data,
  output logic       new_rx_data,
  output logic       frame_err,
  output logic       parity_err,
  output logic       rx_busy
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] STOP   = 3'd4;
  localparam logic [2:0] BRK    = 3'd5;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd3;
`endif

  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(BAUD_DIV - 1);

  // Majority of three samples; tolerates one noisy sample per bit.
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Even parity check over data plus received parity bit: 1 means mismatch.
  function automatic logic even_parity_bad(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction

  logic             sin_meta;
  logic             sin;
  logic [CNT_W-1:0] cnt;
  logic             tick16;
  logic [3:0]       smp;
  logic             v7;
  logic             v8;
  logic             vote;
  logic             bit_val;
  logic [7:0]       shreg;
  logic [2:0]       bit_idx;
  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic             at_vote;
  logic             at_end;
  logic             good_stop;
  logic             bad_stop;
`ifdef UART_RX_PARITY_EN
  logic             par_bit;
`endif

  assign tick16    = (cnt == TICK_LAST);
  assign at_vote   = tick16 && (smp == 4'd9);
  assign at_end    = tick16 && (smp == 4'd15);
  assign vote      = majority3(v7, v8, sin);
  assign good_stop = (state == STOP) && at_vote && vote;
  assign bad_stop  = (state == STOP) && at_vote && !vote;

  // Two-flop synchroniser for the asynchronous line; idles high.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sin_meta <= 1'b1;
      sin      <= 1'b1;
    end else begin
      sin_meta <= ser_in;
      sin      <= sin_meta;
    end
  end

  // Free-running baud divider producing the 16x oversampling tick.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (tick16) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Sample counter: restarts when a start edge is seen, otherwise counts ticks.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      smp <= 4'd0;
    end else if ((state == IDLE) && (state_nxt == START)) begin
      smp <= 4'd0;
    end else if (tick16) begin
      smp <= smp + 4'd1;
    end else begin
      smp <= smp;
    end
  end

  // Capture the first two of the three mid-bit samples and the voted bit.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      v7      <= 1'b0;
      v8      <= 1'b0;
      bit_val <= 1'b0;
    end else begin
      if (tick16 && (smp == 4'd7)) begin
        v7 <= sin;
      end
      if (tick16 && (smp == 4'd8)) begin
        v8 <= sin;
      end
      if (at_vote) begin
        bit_val <= vote;
      end
    end
  end

  // Next-state logic for the framing FSM.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (!sin) begin
          state_nxt = START;
        end else begin
          state_nxt = IDLE;
        end
      end
      START: begin
        if (at_vote && vote) begin
          state_nxt = IDLE;
        end else if (at_end) begin
          state_nxt = DATA;
        end else begin
          state_nxt = START;
        end
      end
      DATA: begin
        if (at_end && (bit_idx == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
          state_nxt = PARITY;
`else
          state_nxt = STOP;
`endif
        end else begin
          state_nxt = DATA;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (at_end) begin
          state_nxt = STOP;
        end else begin
          state_nxt = PARITY;
        end
      end
`endif
      STOP: begin
        if (at_vote) begin
          state_nxt = vote ? IDLE : BRK;
        end else begin
          state_nxt = STOP;
        end
      end
      BRK: begin
        if (sin) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = BRK;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // FSM state register; rx_busy is registered from the next state so it
  // tracks state != IDLE exactly.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      rx_busy <= 1'b0;
    end else begin
      state   <= state_nxt;
      rx_busy <= (state_nxt != IDLE);
    end
  end

  // Data shift register, LSB first, committed at the end of each bit slot.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shreg   <= 8'h00;
      bit_idx <= 3'd0;
    end else if ((state == START) && at_end) begin
      bit_idx <= 3'd0;
    end else if ((state == DATA) && at_end) begin
      shreg   <= {bit_val, shreg[7:1]};
      bit_idx <= bit_idx + 3'd1;
    end else begin
      shreg   <= shreg;
      bit_idx <= bit_idx;
    end
  end

`ifdef UART_RX_PARITY_EN
  // Hold the voted parity bit until the stop bit decision.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      par_bit <= 1'b0;
    end else if ((state == PARITY) && at_vote) begin
      par_bit <= vote;
    end else begin
      par_bit <= par_bit;
    end
  end
`endif

  // Registered result strobes; a good byte updates rx_data, a bad stop does not.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_data     <= 8'h00;
      new_rx_data <= 1'b0;
      frame_err   <= 1'b0;
      parity_err  <= 1'b0;
    end else begin
      new_rx_data <= good_stop;
      frame_err   <= bad_stop;
      if (good_stop) begin
        rx_data <= shreg;
      end
`ifdef UART_RX_PARITY_EN
      parity_err <= good_stop && even_parity_bad(shreg, par_bit);
`else
      parity_err <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx with BAUD_DIV=4 (64 clocks per bit).
module tb_uart_rx;

  localparam int BIT = 64;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       ser_in = 1'b1;
  logic [7:0] rx_data;
  logic       new_rx_data;
  logic       frame_err;
  logic       parity_err;
  logic       rx_busy;

  uart_rx #(.BAUD_DIV(4)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .ser_in      (ser_in),
    .rx_data     (rx_data),
    .new_rx_data (new_rx_data),
    .frame_err   (frame_err),
    .parity_err  (parity_err),
    .rx_busy     (rx_busy)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // cycle counter
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // strobe monitor
  int n_new = 0;
  int n_ferr = 0;
  int n_perr = 0;
  int n_both = 0;
  int last_new_cyc = 0;
  logic [7:0] rxq[$];
  always @(negedge clock) begin
    if (new_rx_data) begin
      n_new <= n_new + 1;
      rxq.push_back(rx_data);
      last_new_cyc <= cyc;
    end
    if (frame_err) n_ferr <= n_ferr + 1;
    if (parity_err) n_perr <= n_perr + 1;
    if (new_rx_data && frame_err) n_both <= n_both + 1;
  end

  int   start_cyc;
  logic busy_mid;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
    end
  endtask

  function automatic int rx_at(input int i);
    if (i < rxq.size()) return int'(rxq[i]);
    else return -1;
  endfunction

  // Drive one frame; called at a negedge, returns at a negedge with the
  // line still at the stop-bit level.
  task automatic send_byte(input logic [7:0] d, input logic stop, input logic par_ok, input int per);
    ser_in = 1'b0;
    start_cyc = cyc;
    repeat (per) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      ser_in = d[i];
      repeat (per) @(negedge clock);
      if (i == 3) busy_mid = rx_busy;
    end
`ifdef UART_RX_PARITY_EN
    ser_in = par_ok ? (^d) : ~(^d);
    repeat (per) @(negedge clock);
`endif
    ser_in = stop;
    repeat (per) @(negedge clock);
  endtask

  task automatic idle(input int n);
    ser_in = 1'b1;
    repeat (n) @(negedge clock);
  endtask

  typedef struct {
    logic [7:0] d;
    logic       stop;
    int         exp_new;
    logic [7:0] exp_data;
    int         exp_ferr;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int b_new, b_ferr, b_perr, b_q, w, n55;

    tbl[0] = '{d: 8'hA5, stop: 1'b1, exp_new: 1, exp_data: 8'hA5, exp_ferr: 0};
    tbl[1] = '{d: 8'h00, stop: 1'b1, exp_new: 1, exp_data: 8'h00, exp_ferr: 0};
    tbl[2] = '{d: 8'hFF, stop: 1'b1, exp_new: 1, exp_data: 8'hFF, exp_ferr: 0};
    tbl[3] = '{d: 8'h55, stop: 1'b0, exp_new: 0, exp_data: 8'hFF, exp_ferr: 1};
    tbl[4] = '{d: 8'h3C, stop: 1'b1, exp_new: 1, exp_data: 8'h3C, exp_ferr: 0};
    tbl[5] = '{d: 8'h81, stop: 1'b1, exp_new: 1, exp_data: 8'h81, exp_ferr: 0};

    // reset state
    repeat (4) @(negedge clock);
    chk("reset_outputs", {rx_data, new_rx_data, frame_err, parity_err, rx_busy}, 0);
    reset_n = 1'b1;
    idle(2 * BIT);
    chk("idle_busy", rx_busy, 0);

    // table-driven single frames with idle gaps
    for (int i = 0; i < 6; i++) begin
      b_new = n_new; b_ferr = n_ferr;
      send_byte(tbl[i].d, tbl[i].stop, 1'b1, BIT);
      idle(3 * BIT);
      chk($sformatf("v%0d_new_count", i), n_new - b_new, tbl[i].exp_new);
      chk($sformatf("v%0d_rx_data", i), rx_data, tbl[i].exp_data);
      chk($sformatf("v%0d_ferr_count", i), n_ferr - b_ferr, tbl[i].exp_ferr);
      chk($sformatf("v%0d_busy_mid", i), busy_mid, 1);
      chk($sformatf("v%0d_busy_after", i), rx_busy, 0);
      if (tbl[i].exp_new == 1)
        chk_range($sformatf("v%0d_latency", i), last_new_cyc - start_cyc, 596, 628);
    end

    // glitch on the line: rejected in START
    b_new = n_new; b_ferr = n_ferr;
    ser_in = 1'b0;
    repeat (16) @(negedge clock);
    ser_in = 1'b1;
    chk("glitch_busy_during", rx_busy, 1);
    w = 0;
    while (rx_busy && w < 48) begin
      @(negedge clock);
      w++;
    end
    chk("glitch_busy_clear", rx_busy, 0);
    idle(2 * BIT);
    chk("glitch_no_new", n_new - b_new, 0);
    chk("glitch_no_ferr", n_ferr - b_ferr, 0);

    // framing error followed by a held-low line, then a good byte
    b_new = n_new; b_ferr = n_ferr; b_q = rxq.size();
    send_byte(8'h55, 1'b0, 1'b1, BIT);
    repeat (3 * BIT) @(negedge clock);
    chk("break_busy_held", rx_busy, 1);
    chk("break_ferr_count", n_ferr - b_ferr, 1);
    idle(8);
    chk("break_busy_released", rx_busy, 0);
    idle(BIT);
    send_byte(8'h01, 1'b1, 1'b1, BIT);
    idle(3 * BIT);
    chk("break_new_count", n_new - b_new, 1);
    chk("break_rx_data", rx_data, 8'h01);
    n55 = 0;
    for (int i = b_q; i < rxq.size(); i++) if (rxq[i] == 8'h55) n55++;
    chk("break_no_55", n55, 0);

    // back-to-back frames at -3% bit period
    b_new = n_new; b_q = rxq.size();
    send_byte(8'hAA, 1'b1, 1'b1, 62);
    send_byte(8'h00, 1'b1, 1'b1, 62);
    idle(3 * BIT);
    chk("b2b_new_count", n_new - b_new, 2);
    chk("b2b_first", rx_at(b_q), 8'hAA);
    chk("b2b_second", rx_at(b_q + 1), 8'h00);

    // reset during bit 4 of 0xFF, then 0x3C
    b_new = n_new; b_q = rxq.size();
    ser_in = 1'b0;
    repeat (BIT) @(negedge clock);
    ser_in = 1'b1;
    repeat (4 * BIT + BIT / 2) @(negedge clock);
    chk("rst_busy_before", rx_busy, 1);
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk($sformatf("rst_outputs_%0d", i), {rx_data, new_rx_data, frame_err, parity_err, rx_busy}, 0);
    end
    reset_n = 1'b1;
    idle(5 * BIT);
    send_byte(8'h3C, 1'b1, 1'b1, BIT);
    idle(3 * BIT);
    chk("rst_new_count", n_new - b_new, 1);
    chk("rst_rx_data", rx_at(b_q), 8'h3C);

`ifdef UART_RX_PARITY_EN
    // parity: bad parity bit then good parity bit for 0x07
    b_new = n_new; b_perr = n_perr;
    send_byte(8'h07, 1'b1, 1'b0, BIT);
    idle(3 * BIT);
    chk("par_bad_new", n_new - b_new, 1);
    chk("par_bad_perr", n_perr - b_perr, 1);
    chk("par_bad_data", rx_data, 8'h07);
    b_new = n_new; b_perr = n_perr;
    send_byte(8'h07, 1'b1, 1'b1, BIT);
    idle(3 * BIT);
    chk("par_good_new", n_new - b_new, 1);
    chk("par_good_perr", n_perr - b_perr, 0);
`else
    chk("no_parity_err", n_perr, 0);
`endif

    chk("never_new_and_ferr", n_both, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
